// File: rtl/cvp14_mem_responder.sv
// cvp14_mem_responder
// Word-addressed single-port memory answering CVP14 bus requests. It handles
// one read or write per Clk1 edge and returns read data one cycle later.
// A burst tracker checks vector (V=1) transfers for sequential addresses and
// a consistent direction. Range, conflict and burst violations are reported
// on BusErr and accumulated in ErrSticky.

module cvp14_mem_responder #(
    parameter int AW        = 12,
    parameter int BURST_LEN = 16,
    parameter int CW        = $clog2(BURST_LEN + 1)
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic [15:0]   Addr,
    input  logic          RD,
    input  logic          WR,
    input  logic          V,
    input  logic [15:0]   WrData,
    output logic [15:0]   RdData,
    output logic          RdValid,
    output logic [CW-1:0] BurstCount,
    output logic          BurstDone,
    output logic          BusErr,
    output logic          ErrSticky
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

    // Storage
    logic [15:0] mem [0:DEPTH-1];

    // Access decode
    logic          in_range;
    logic [AW-1:0] idx;
    logic          rd_op;
    logic          wr_op;
    logic          conflict;
    logic          any_acc;
    logic          xfer_ok;
    logic          range_err;
    dir_t          acc_dir;

    // Registered state
    state_t        state_q,      state_d;
    logic [15:0]   base_q,       base_d;
    dir_t          dir_q,        dir_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [15:0]   rd_data_q,    rd_data_d;
    logic          rd_valid_q,   rd_valid_d;
    logic          burst_done_q, burst_done_d;
    logic          bus_err_q,    bus_err_d;
    logic          err_sticky_q, err_sticky_d;

    // Burst helpers
    logic [CW-1:0] cnt_inc;
    logic [15:0]   exp_addr;
    logic          burst_err;
    logic          beat_legal;

    // Upper address bits must be zero; with a full 16-bit array every address hits.
    generate
        if (AW < 16) begin : g_range_check
            assign in_range = (Addr[15:AW] == '0);
        end else begin : g_full_range
            assign in_range = 1'b1;
        end
    endgenerate

    assign idx = Addr[AW-1:0];

    // Classify the request seen at this edge.
    always_comb begin
        rd_op     = RD & ~WR;
        wr_op     = WR & ~RD;
        conflict  = RD & WR;
        any_acc   = RD | WR;
        xfer_ok   = (rd_op | wr_op) & in_range;
        range_err = (rd_op | wr_op) & ~in_range;
        acc_dir   = wr_op ? DIR_WR : DIR_RD;
    end

    // Read data path: out-of-range reads return zero, idle cycles hold the last data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_op) begin
            rd_valid_d = 1'b1;
            rd_data_d  = in_range ? mem[idx] : 16'h0000;
        end
    end

    // Burst tracker next state: start, advance, complete or abort.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        burst_done_d = 1'b0;
        burst_err    = 1'b0;
        cnt_inc      = cnt_q + 1'b1;
        exp_addr     = base_q + 16'(cnt_q);
        beat_legal   = V & ~conflict & (acc_dir == dir_q) & (Addr == exp_addr);

        case (state_q)
            ST_IDLE: begin
                if (V && xfer_ok) begin
                    if (BURST_LEN == 1) begin
                        burst_done_d = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        base_d  = Addr;
                        dir_d   = acc_dir;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_BURST: begin
                // A cycle with no access is a legal gap inside the burst.
                if (any_acc) begin
                    if (beat_legal) begin
                        if (cnt_inc == CW'(BURST_LEN)) begin
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            burst_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // The aborting access is still performed by the decode; it never opens a new burst.
                        burst_err = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Error flags: all violations at one edge merge into a single pulse.
    always_comb begin
        bus_err_d    = range_err | conflict | burst_err;
        err_sticky_d = err_sticky_q | bus_err_d;
    end

    // Control and output registers; requests during Reset are ignored.
    always_ff @(posedge Clk1) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            dir_q        <= DIR_RD;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            burst_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            burst_done_q <= burst_done_d;
            bus_err_q    <= bus_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Array write port; writes presented during Reset are dropped.
    always_ff @(posedge Clk1) begin
        // NOTE: the array has no reset so it maps onto plain RAM and keeps its contents across Reset.
        if (!Reset && wr_op && in_range) begin
            mem[idx] <= WrData;
        end
    end

    assign RdData     = rd_data_q;
    assign RdValid    = rd_valid_q;
    assign BurstCount = cnt_q;
    assign BurstDone  = burst_done_q;
    assign BusErr     = bus_err_q;
    assign ErrSticky  = err_sticky_q;

endmodule

// File: doc/cvp14_mem_responder.md
# cvp14_mem_responder

Single-port word-addressed memory that sits on the far side of the CVP14 processor bus and answers its `Addr`/`RD`/`WR`/`V` requests. It services one read or write per `Clk1` edge and returns read data with one cycle of latency, which matches the processor's sample-next-state convention. A burst tracker checks vector transfers (`V`=1) for sequential addresses and a consistent direction. It flags protocol violations on a bus-error output.

## Interface
- `AW`, default 12: implemented address bits; depth is 2^AW 16-bit words.
- `BURST_LEN`, default 16: beats in one vector transfer, matching the 256-bit vector.
- `CW`, default $clog2(BURST_LEN+1): width of the burst beat counter.

Ports:
- `Clk1`  in  1  system clock; all state changes on the posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `Addr`  in  16  word address from the processor.
- `RD`  in  1  read request for this cycle.
- `WR`  in  1  write request for this cycle.
- `V`  in  1  the access is one beat of a vector burst.
- `WrData`  in  16  write data; connects to the processor `dataOut`.
- `RdData`  out  16  read data; connects to the processor `DataIn`.
- `RdValid`  out  1  `RdData` was produced by the read sampled on the previous edge.
- `BurstCount`  out  CW  beats accepted in the current burst; 0 when idle.
- `BurstDone`  out  1  one-cycle pulse after the final burst beat.
- `BusErr`  out  1  one-cycle pulse after any protocol or range violation.
- `ErrSticky`  out  1  set by any `BusErr`; cleared only by `Reset`.

## Operation
- **Array:** 2^AW x 16 register array. It has no reset, so contents survive `Reset`.
- **In-range test:** `Addr[15:AW]==0`. The array index is `Addr[AW-1:0]`.
- **Access decode at each edge (`Reset`=0):**
  - `RD & ~WR` is a read. If in range, `RdData <= mem[idx]`; if out of range, `RdData <= 16'h0000` and `BusErr`. `RdValid <= 1` in both cases.
  - `WR & ~RD` is a write. If in range, `mem[idx] <= WrData`; if out of range, nothing is written and `BusErr` fires.
  - `RD & WR` is a conflict. No read, no write, `BusErr`. `RdValid <= 0`.
  - No access: `RdValid <= 0`. `RdData` holds its previous value.
- **Burst FSM states:** IDLE and BURST. The FSM also registers `base` (16 bits), `dir` (read/write) and `cnt` (CW bits). `BurstCount = cnt`.
- **In IDLE:**
  - A valid access with `V`=1 latches `base<=Addr`, `dir` and `cnt<=1`, then moves to BURST.
  - If `BURST_LEN`=1, the FSM stays in IDLE and `BurstDone` fires instead.
- **In BURST:**
  - A cycle with no access is a legal gap; state is unchanged.
  - A beat is legal when it has `V`=1, the same `dir`, and `Addr == base+cnt`. The sum is 16 bits, modulo 2^16.
  - A legal beat sets `cnt<=cnt+1`. When `cnt+1 == BURST_LEN`, the FSM goes to IDLE, sets `cnt<=0` and pulses `BurstDone`.
  - An illegal beat (wrong address, direction flip, or an access with `V`=0) fires `BusErr`, aborts to IDLE and sets `cnt<=0`. The access itself is still performed under the normal decode rules.
  - An aborting access with `V`=1 does not start a new burst.
- **Conflicts:** an `RD&WR` conflict inside a burst aborts the burst; `BusErr` fires once.
- **Error flags:** `BusErr` is the OR of all violations at that edge, so at most one pulse per edge. `ErrSticky <= ErrSticky | BusErr_next`.

## Timing
- **Reset values:** `RdData=0`, `RdValid=0`, `BurstCount=0`, `BurstDone=0`, `BusErr=0`, `ErrSticky=0`, FSM=IDLE.
  - Requests present during a `Reset` cycle are ignored, including writes.
  - A reset in the middle of a burst returns the FSM to IDLE without raising `BusErr`.
- **Read latency:** a read sampled at edge k has `RdData`/`RdValid` valid from edge k+1 until edge k+2.
- **Back-to-back access:** reads on consecutive edges return data on consecutive cycles, giving full throughput.
- **Write then read, same address:** a write at edge k followed by a read at edge k+1 returns the new data after edge k+2.
- **Output registering:** `BusErr` and `BurstDone` are registered, asserted for exactly the one cycle after the causing edge.
- **Burst boundaries:**
  - A new burst may start on the edge immediately after the final beat.
  - 16 consecutive beats take 16 edges. `BurstDone` is high in the cycle after the 16th beat, when `BurstCount` has already returned to 0.

## Test plan
- **Reset/readback:** assert Reset for 2 cycles, then read 0x0000. All outputs are 0 during reset. Write 0x1234 to 0x0005, then read 0x0005: `RdData`=0x1234 with `RdValid`=1 exactly one cycle after the read edge.
- **Read burst:** `V`=1, reads at 0x0100..0x010F with a 2-cycle gap after beat 7. `BurstCount` steps 1..15, then 0. `BurstDone` pulses once after beat 16. `BusErr` stays 0.
- **Burst violations:** burst starts at 0x0200; beat 3 goes to 0x0204. `BusErr` pulses, FSM returns to IDLE, `BurstCount`=0, and `RdData`=mem[0x0204]. Repeat with a write on beat 2: same error and abort, and the write is performed.
- **Range and conflict:** write to 0xF000 (AW=12) leaves the array unchanged and pulses `BusErr`. A read at 0xF000 returns 0x0000 with `BusErr`. `RD`=`WR`=1 performs no write and gives `RdValid`=0, `BusErr`=1. `ErrSticky`=1 until Reset.
- **Reset mid-burst:** assert Reset after beat 5 while `WR`=1. That write is not performed. FSM=IDLE, `BusErr`=0, and the memory contents from beats 1-5 are still readable afterwards.
- **Address wrap:** with `AW`=16, a burst starting at 0xFFFE continues legally at 0xFFFF, then 0x0000; no `BusErr` on the wrap.
